// File: rtl/arbiter_game_ctrl.sv
// arbiter_game_ctrl: round sequencer for the two-player reaction game.
// Holds the countdown block in reset while idle, flags false starts during
// the countdown, picks the first valid press in the race and holds the
// result for a fixed time.
// Optional feature macro: ARB_SCORE_EN (per-player saturating score counters).
module arbiter_game_ctrl #(
  parameter int CLOCK_FREQ          = 12000000,
  parameter int RACE_TIMEOUT_CYCLES = 3*CLOCK_FREQ,
  parameter int RESULT_HOLD_CYCLES  = 2*CLOCK_FREQ,
  parameter int SCORE_BITS          = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_in,
  input  logic                  p1_btn_in,
  input  logic                  p2_btn_in,
  input  logic                  cd_done_in,
  output logic                  cd_reset_out,
  output logic                  busy_out,
  output logic [1:0]            winner_out,
  output logic                  foul_out,
  output logic [SCORE_BITS-1:0] p1_score_out,
  output logic [SCORE_BITS-1:0] p2_score_out
);

  localparam int NUM_IN  = 3;  // [0] start, [1] p1, [2] p2
  localparam int CNT_MAX = (RACE_TIMEOUT_CYCLES > RESULT_HOLD_CYCLES) ?
                           RACE_TIMEOUT_CYCLES : RESULT_HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RACE_LAST = CW'(RACE_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESULT_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_RACE, S_RESULT} state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: 2-FF sync, edge history, registered pulse
  // ---------------------------------------------------------------------
  logic [NUM_IN-1:0] pin, sync1, sync2, hist, pulse_q;
  logic              start_p, p1_p, p2_p;

  assign pin = {p2_btn_in, p1_btn_in, start_in};

  // Sync stages and history reset high so a pin already high at reset
  // release looks like a steady level, never a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '1;
      sync2   <= '1;
      hist    <= '1;
      pulse_q <= '0;
    end else begin
      sync1   <= pin;
      sync2   <= sync1;
      hist    <= sync2;
      pulse_q <= sync2 & ~hist;
    end
  end

  assign start_p = pulse_q[0];
  assign p1_p    = pulse_q[1];
  assign p2_p    = pulse_q[2];

  // ---------------------------------------------------------------------
  // Round state machine
  // ---------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     winner_q, winner_d;
  logic           foul_q, foul_d;
  logic           cd_reset_q, busy_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and next result; false start outranks countdown end.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    foul_d   = foul_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d  = S_COUNTDOWN;
          winner_d = 2'b00;
          foul_d   = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (p1_p || p2_p) begin
          // The player who jumped the gun loses: bit1 = p1 fouled, bit0 = p2 fouled.
          state_d  = S_RESULT;
          winner_d = {p1_p, p2_p};
          foul_d   = 1'b1;
        end else if (cd_done_in) begin
          state_d = S_RACE;
        end
      end
      S_RACE: begin
        if (p1_p || p2_p) begin
          state_d  = S_RESULT;
          winner_d = {p2_p, p1_p};
          foul_d   = 1'b0;
        end else if (cnt_q == RACE_LAST) begin
          state_d  = S_RESULT;
          winner_d = 2'b00;
          foul_d   = 1'b0;
        end
      end
      S_RESULT: begin
        if (cnt_q == HOLD_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shared timeout/hold counter plus registered outputs taken from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      winner_q   <= 2'b00;
      foul_q     <= 1'b0;
      cd_reset_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      winner_q   <= winner_d;
      foul_q     <= foul_d;
      cd_reset_q <= (state_d != S_COUNTDOWN);
      busy_q     <= (state_d != S_IDLE);
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == S_RACE || state_q == S_RESULT)
        cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cd_reset_out = cd_reset_q;
  assign busy_out     = busy_q;
  assign winner_out   = winner_q;
  assign foul_out     = foul_q;

  // ---------------------------------------------------------------------
  // Scores
  // ---------------------------------------------------------------------
`ifdef ARB_SCORE_EN
  logic [SCORE_BITS-1:0] p1_sc_q, p2_sc_q;
  logic                  enter_result;

  assign enter_result = (state_d == S_RESULT) && (state_q != S_RESULT);

  // Saturating win counters, bumped on the edge that enters RESULT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_sc_q <= '0;
      p2_sc_q <= '0;
    end else if (enter_result) begin
      if (winner_d[0] && (p1_sc_q != '1)) p1_sc_q <= p1_sc_q + SCORE_BITS'(1);
      if (winner_d[1] && (p2_sc_q != '1)) p2_sc_q <= p2_sc_q + SCORE_BITS'(1);
    end
  end

  assign p1_score_out = p1_sc_q;
  assign p2_score_out = p2_sc_q;
`else
  assign p1_score_out = '0;
  assign p2_score_out = '0;
`endif

endmodule

// File: tb/tb_arbiter_game_ctrl.sv
// Self-checking bench for arbiter_game_ctrl: table of round scenarios plus
// hand-written sequences for latency, timeout boundary, ignored inputs,
// score saturation and reset mid-round.
module tb_arbiter_game_ctrl;
  localparam int RT = 20;
  localparam int RH = 10;
  localparam int SB = 4;
  localparam int SMAX = (1 << SB) - 1;

  logic clk = 1'b0;
  logic reset_n, start_in, p1_btn_in, p2_btn_in, cd_done_in;
  logic cd_reset_out, busy_out, foul_out;
  logic [1:0] winner_out;
  logic [SB-1:0] p1_score_out, p2_score_out;

  int n_tests = 0;
  int n_fail  = 0;
  int sc1 = 0;
  int sc2 = 0;

  always #5 clk = ~clk;

  arbiter_game_ctrl #(
    .CLOCK_FREQ(12000000), .RACE_TIMEOUT_CYCLES(RT),
    .RESULT_HOLD_CYCLES(RH), .SCORE_BITS(SB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_in(start_in),
    .p1_btn_in(p1_btn_in), .p2_btn_in(p2_btn_in), .cd_done_in(cd_done_in),
    .cd_reset_out(cd_reset_out), .busy_out(busy_out),
    .winner_out(winner_out), .foul_out(foul_out),
    .p1_score_out(p1_score_out), .p2_score_out(p2_score_out)
  );

  // mode: 0 press in race, 1 press in countdown, 2 race timeout,
  //       3 press whose pulse coincides with cd_done_in
  typedef struct {
    string      name;
    int         mode;
    int         cd_len;
    int         race_dly;
    logic       p1;
    logic       p2;
    logic [1:0] exp_w;
    logic       exp_f;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_win(input logic [1:0] w);
    if (w[0] && sc1 < SMAX) sc1++;
    if (w[1] && sc2 < SMAX) sc2++;
  endtask

  task automatic chk_scores(input string nm);
`ifdef ARB_SCORE_EN
    chk({nm, "_p1sc"}, 32'(p1_score_out), 32'(sc1));
    chk({nm, "_p2sc"}, 32'(p2_score_out), 32'(sc2));
`else
    chk({nm, "_p1sc"}, 32'(p1_score_out), 0);
    chk({nm, "_p2sc"}, 32'(p2_score_out), 0);
`endif
  endtask

  // Rising edge on start_in; COUNTDOWN is entered exactly 4 edges later.
  task automatic start_round();
    start_in = 1'b1;
    tick(4);
    start_in = 1'b0;
    chk("start_busy", busy_out, 1);
    chk("start_cdrst", cd_reset_out, 0);
  endtask

  task automatic enter_race();
    start_round();
    cd_done_in = 1'b1;
    tick(1);
    cd_done_in = 1'b0;
    chk("race_cdrst", cd_reset_out, 1);
  endtask

  // Button pulse reaches the FSM edge 4 edges after the pin rises.
  task automatic press(input logic a, input logic b);
    p1_btn_in = a; p2_btn_in = b;
    tick(2);
    p1_btn_in = 1'b0; p2_btn_in = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy_out && k < 40) begin
      tick(1);
      k++;
    end
    chk(nm, busy_out, 0);
  endtask

  task automatic run_vec(input vec_t v);
    start_round();
    tick(v.cd_len);
    if (v.mode == 1) begin
      press(v.p1, v.p2);
    end else if (v.mode == 3) begin
      p1_btn_in = v.p1; p2_btn_in = v.p2;
      tick(2);
      p1_btn_in = 1'b0; p2_btn_in = 1'b0;
      tick(1);
      cd_done_in = 1'b1;
      tick(1);
      cd_done_in = 1'b0;
    end else begin
      cd_done_in = 1'b1;
      tick(1);
      cd_done_in = 1'b0;
      chk({v.name, "_cdrst_race"}, cd_reset_out, 1);
      if (v.mode == 0) begin
        tick(v.race_dly);
        press(v.p1, v.p2);
      end else begin
        tick(RT);
      end
    end
    chk({v.name, "_winner"}, 32'(winner_out), 32'(v.exp_w));
    chk({v.name, "_foul"}, foul_out, 32'(v.exp_f));
    chk({v.name, "_cdrst_res"}, cd_reset_out, 1);
    add_win(v.exp_w);
    chk_scores(v.name);
    wait_idle({v.name, "_idle"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"p1_win",   0, 100, 10, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[1] = '{"p2_win",   0,  10,  3, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[2] = '{"race_tie", 0,  10,  0, 1'b1, 1'b1, 2'b11, 1'b0};
    vecs[3] = '{"fs_p2",    1,   5,  0, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[4] = '{"fs_p1",    1,   5,  0, 1'b1, 1'b0, 2'b10, 1'b1};
    vecs[5] = '{"fs_both",  1,   5,  0, 1'b1, 1'b1, 2'b11, 1'b1};
    vecs[6] = '{"timeout",  2,   8,  0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[7] = '{"fs_at_cd", 3,   6,  0, 1'b1, 1'b0, 2'b10, 1'b1};

    reset_n = 1'b0; start_in = 1'b0; p1_btn_in = 1'b0;
    p2_btn_in = 1'b0; cd_done_in = 1'b0;
    tick(3);
    chk("rst_cdrst", cd_reset_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_winner", 32'(winner_out), 0);
    chk("rst_foul", foul_out, 0);
    chk_scores("rst");
    reset_n = 1'b1;
    tick(4);

    // Pin-to-output latency is exactly 4 edges.
    start_in = 1'b1;
    tick(3);
    chk("lat_busy_early", busy_out, 0);
    tick(1);
    start_in = 1'b0;
    chk("lat_busy", busy_out, 1);
    chk("lat_cdrst", cd_reset_out, 0);
    // Timeout then hold: busy falls exactly RT+RH edges after RACE entry.
    cd_done_in = 1'b1;
    tick(1);
    cd_done_in = 1'b0;
    chk("to_cdrst", cd_reset_out, 1);
    tick(RT + RH - 1);
    chk("to_busy_hold", busy_out, 1);
    tick(1);
    chk("to_busy_fall", busy_out, 0);
    chk("to_winner", 32'(winner_out), 0);
    chk_scores("to");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Press whose pulse lands on the last RACE cycle still wins.
    enter_race();
    tick(RT - 4);
    press(1'b1, 1'b0);
    chk("edge_last_winner", 32'(winner_out), 32'(2'b01));
    add_win(2'b01);
    wait_idle("edge_last_idle");
    // One cycle later the round has already timed out.
    enter_race();
    tick(RT - 3);
    press(1'b1, 1'b0);
    chk("edge_late_winner", 32'(winner_out), 0);
    wait_idle("edge_late_idle");
    chk_scores("edge");

    // Buttons in IDLE are ignored; result from last round is kept.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    tick(4);
    chk("idle_btn_busy", busy_out, 0);
    chk("idle_btn_winner", 32'(winner_out), 0);

    // start_in during RACE is ignored, presses during RESULT are ignored.
    enter_race();
    start_in = 1'b1;
    tick(4);
    start_in = 1'b0;
    press(1'b0, 1'b1);
    chk("ign_race_winner", 32'(winner_out), 32'(2'b10));
    add_win(2'b10);
    press(1'b1, 1'b0);
    chk("ign_res_winner", 32'(winner_out), 32'(2'b10));
    chk("ign_res_foul", foul_out, 0);
    wait_idle("ign_idle");
    tick(6);
    chk("ign_no_restart", busy_out, 0);
    chk_scores("ign");

    // Saturation: 17 P1 wins.
    for (int r = 0; r < 17; r++) begin
      enter_race();
      press(1'b1, 1'b0);
      add_win(2'b01);
      wait_idle("sat_idle");
    end
    chk("sat_winner", 32'(winner_out), 32'(2'b01));
    chk_scores("sat");

    // Reset in the middle of RACE with start and p1 held through release.
    enter_race();
    tick(3);
    p1_btn_in = 1'b1;
    start_in  = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_cdrst", cd_reset_out, 1);
    chk("mid_rst_winner", 32'(winner_out), 0);
    chk("mid_rst_foul", foul_out, 0);
    sc1 = 0; sc2 = 0;
    chk_scores("mid_rst");
    tick(2);
    reset_n = 1'b1;
    tick(8);
    chk("held_start_no_pulse", busy_out, 0);
    start_in = 1'b0;
    tick(3);
    // p1 still held: no new edge, so the race times out.
    enter_race();
    tick(RT);
    chk("held_btn_winner", 32'(winner_out), 0);
    p1_btn_in = 1'b0;
    wait_idle("held_idle");
    chk_scores("held");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arbiter_game_ctrl.md
# arbiter_game_ctrl

Top-level sequencer for the two-player reaction game. It holds the countdown block in reset until a round is started, then releases it. It watches both player buttons, flags false starts during the countdown and picks the first valid press once the countdown ends. The result is held on the outputs for a fixed time. Optional per-player score counters follow the round outcomes.

## Interface
Parameters:
- `CLOCK_FREQ`, 12000000, system clock frequency in Hz.
- `RACE_TIMEOUT_CYCLES`, `3*CLOCK_FREQ`, maximum time in RACE before the round ends with no winner.
- `RESULT_HOLD_CYCLES`, `2*CLOCK_FREQ`, time the result is held before returning to IDLE.
- `SCORE_BITS`, 4, width of each score counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_in`  in  1  round start request; asynchronous, level input.
- `p1_btn_in`  in  1  player 1 button; asynchronous, active-high.
- `p2_btn_in`  in  1  player 2 button; asynchronous, active-high.
- `cd_done_in`  in  1  `cd_done_out` of the countdown block.
- `cd_reset_out`  out  1  active-high reset driven to the countdown block.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `winner_out`  out  2  bit0 = P1 wins, bit1 = P2 wins; 11 = tie, 00 = none.
- `foul_out`  out  1  the result was decided by a false start.
- `p1_score_out`  out  SCORE_BITS  P1 round wins.
- `p2_score_out`  out  SCORE_BITS  P2 round wins.

## Operation
- **Input conditioning.**
  - `start_in`, `p1_btn_in` and `p2_btn_in` each pass through a 2-FF synchronizer.
  - A rising-edge detector follows each synchronizer, giving one-cycle pulses `start_p`, `p1_p` and `p2_p`.
  - Edge-detector history registers reset to 1, so an input already high when reset is released does not produce a pulse.
- **State machine:** IDLE, COUNTDOWN, RACE, RESULT. Reset state is IDLE.
- **IDLE.**
  - `cd_reset_out`=1.
  - `start_p` moves to COUNTDOWN and clears `winner_out` and `foul_out`.
  - Button pulses are ignored.
- **COUNTDOWN.**
  - `cd_reset_out`=0.
  - Priority order: false start, then countdown end.
  - False start: if `p1_p` and `p2_p` arrive in the same cycle, move to RESULT with winner 11 and foul 1. If only `p1_p` arrives, winner 10 (P2 wins) and foul 1. If only `p2_p` arrives, winner 01 and foul 1.
  - Otherwise, `cd_done_in`=1 moves to RACE. A press in that same cycle still counts as a false start.
- **RACE.**
  - `cd_reset_out`=1.
  - A timeout counter starts at 0 on entry.
  - `p1_p` alone gives winner 01. `p2_p` alone gives winner 10. Both in the same cycle gives winner 11. In every case foul 0 and the next state is RESULT.
  - If the counter reaches `RACE_TIMEOUT_CYCLES-1` with no press, move to RESULT with winner 00.
- **RESULT.**
  - `cd_reset_out`=1.
  - Outputs are held while a counter runs to `RESULT_HOLD_CYCLES-1`, then the state returns to IDLE.
  - `winner_out` and `foul_out` keep their values in IDLE until the next `start_p`.
  - All inputs are ignored.
- **Counters.** The timeout and hold counters share one counter of width `$clog2(max(RACE_TIMEOUT_CYCLES, RESULT_HOLD_CYCLES))`. It is cleared on every state transition.
- **Scores.** On entry to RESULT:
  - winner bit0 increments `p1_score_out`; winner bit1 increments `p2_score_out`.
  - A tie (11) increments both.
  - Each score saturates at `2^SCORE_BITS-1`.
  - Scores are cleared only by `reset_n`.

## Timing
- **Reset values:** `cd_reset_out`=1, `busy_out`=0, `winner_out`=00, `foul_out`=0, scores 0. All internal registers clear asynchronously on `reset_n`=0.
- **Latency.**
  - A pin rising edge produces its pulse 3 cycles later.
  - All outputs are registered, and the state and outputs update on the clock edge after the pulse.
  - The total from pin edge to output change is 4 cycles.
- **`cd_done_in` path.** Synchronous to `clk` and not resynchronized. RACE is entered on the edge after `cd_done_in` is sampled high, and `cd_reset_out` rises on that same edge.
- **RACE timeout:** exactly `RACE_TIMEOUT_CYCLES` cycles in RACE with no press.
- **RESULT hold:** exactly `RESULT_HOLD_CYCLES` cycles in RESULT.
- **Scores:** update on the same edge that enters RESULT.
- **Reset mid-round:** IDLE is entered immediately, with all outputs at their reset values.

## Configuration
- `ARB_SCORE_EN` defined: score counters exist and behave as described above.
- `ARB_SCORE_EN` undefined: no score registers are built, and `p1_score_out` and `p2_score_out` are tied to 0. The ports remain.

## Test plan
- **Clean P1 win.**
  - Stimulus: `start_in` pulse, `cd_done_in` raised 100 cycles later, then `p1_btn_in` 50 cycles after that.
  - Required: `winner_out`=01, `foul_out`=0, `p1_score_out`=1, and `cd_reset_out` low only during COUNTDOWN.
- **False start.**
  - Stimulus: `p2_btn_in` pressed during COUNTDOWN.
  - Required: `winner_out`=01, `foul_out`=1, RESULT entered without waiting for `cd_done_in`.
- **Simultaneous press.**
  - Stimulus: both buttons in the same cycle during RACE.
  - Required: `winner_out`=11, both scores +1.
  - Repeat the simultaneous press during COUNTDOWN. Required: `winner_out`=11, `foul_out`=1.
- **Timeout and hold.**
  - Stimulus: `RACE_TIMEOUT_CYCLES`=20, `RESULT_HOLD_CYCLES`=10, no press in RACE.
  - Required: RESULT entered after exactly 20 RACE cycles with `winner_out`=00; `busy_out` falls after exactly 10 cycles; scores unchanged.
- **Saturation and ignored inputs.**
  - Stimulus: 17 P1 wins with `SCORE_BITS`=4.
  - Required: `p1_score_out` stays at 15.
  - Button presses in IDLE and RESULT, and `start_in` in RACE, cause no change.
- **Reset mid-round.**
  - Stimulus: `reset_n` low during RACE.
  - Required: outputs go to reset values immediately. A button held high through reset release produces no pulse.
